button_event_queue: RTL
=======================

# button_event_queue

Debounces the four game buttons, turns each clean press into a colour event and queues the events in a small FIFO. The processor drains the FIFO one event per read through the memory-mapped button-poll word (dmem address 7). The block sits between the raw FPGA button pins and the wrapper's `memDataOut` read mux. Its colour codes match the LED-flash encoding, so software can echo a press straight to the LEDs.

## Interface

Parameters
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz). Must be ≥ 2.
- `DEPTH`, default 8: FIFO entries. Must be a power of two, ≥ 2.

Ports
- `clock` in 1: system clock (50 MHz PLL output).
- `reset` in 1: synchronous, active-high.
- `red_button`, `blue_button`, `green_button`, `yellow_button` in 1 each: raw asynchronous pins, active-high (pressed = 1).
- `poll` in 1: high while the processor addresses the button word. Level signal; it may stay high for several cycles.
- `button_out` out 32: read word.
  - bit 2 = valid.
  - bits 1:0 = colour: 00 red, 01 blue, 10 green, 11 yellow.
  - bit 3 = overflow (sticky).
  - bits 31:4 = 0.

## Operation

Input conditioning, per button:
- A 2-FF synchronizer, then a debouncer: a counter plus a `stable` register.
- While the synchronizer output differs from `stable`, the counter increments. When the value differs and the counter equals `DEBOUNCE_CYCLES-1`, `stable` takes the new level and the counter clears.
- Whenever the synchronizer output equals `stable`, the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` therefore never changes `stable`.

Press detection:
- The edge at which `stable` goes 0→1 also sets that button's `pending` flag.
- A release (1→0) generates no event.

Arbiter:
- Each cycle, the highest-priority set `pending` flag is enqueued and cleared. Priority is red > blue > green > yellow, one event per cycle.
- If the FIFO is full and no pop occurs this cycle, the event is dropped: its `pending` clears and `overflow` sets.

FIFO:
- `DEPTH` 2-bit entries with read/write pointers that wrap modulo `DEPTH`, plus a count register from 0 to `DEPTH`.

Pop:
- A pop occurs when `poll` is high and the registered `poll_d` is low (rising edge of `poll`), and the FIFO is non-empty. Exactly one pop happens per poll assertion, however long `poll` is held.
- A pop on an empty FIFO does nothing.
- `overflow` clears on any rising edge of `poll`, with or without a pop.

Simultaneous push and pop:
- When full, both occur: count stays at `DEPTH` and no overflow is flagged.
- When empty, the pop is ignored and the push lands.

`button_out` is combinational from the FIFO head, count and `overflow`:
- Empty FIFO: valid = 0 and colour = 00. Bit 3 still shows `overflow`.
- The processor sees the head during the same cycle it reads. The pop takes effect at the following edge.

Reset:
- Clears synchronizers, `stable` (to 0), counters, `pending`, pointers, count, `overflow` and `poll_d`. `button_out` = 0.
- Reset mid-debounce or with the FIFO non-empty discards everything.
- A button held through reset is seen as a new press once it has been stable for `DEBOUNCE_CYCLES` after reset.

## Timing

Press latency: take edge 0 as the edge at which sync stage 1 first captures the new level.
- Sync stage 2 updates at edge 1.
- `stable` and `pending` update at edge `DEBOUNCE_CYCLES`+1.
- The event is enqueued at edge `DEBOUNCE_CYCLES`+2 (FIFO empty, no other `pending` flags set).
- `button_out` shows valid right after that edge.

Other timing:
- Simultaneous presses on the same cycle are enqueued on consecutive edges in priority order.
- Pop: the head advances on the edge following the first cycle of `poll` high.
- Throughput: at most 1 push and 1 pop per cycle.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `DEPTH`=4.

1. Reset, then pulse `green_button` high for 3 cycles -> `button_out` stays 0. Hold it high for 10 cycles -> `button_out` = 0x6 exactly 6 edges after the first edge that captures the new level. Release -> no further event.
2. Press red, blue, green and yellow on the same cycle, held -> FIFO fills in order. Four polls (each `poll` held 3 cycles, then low 1 cycle) return 0x4, 0x5, 0x6, 0x7; a fifth poll returns 0x0.
3. Fill the FIFO with 4 red presses, then press yellow with no poll -> yellow dropped, `button_out` = 0xC. The next `poll` rising edge reads 0xC; afterwards `button_out` = 0x4 with count 3.
4. FIFO full and a blue press enqueues on the same cycle as a pop -> no overflow, count stays 4, blue is at the tail. Drain -> last read = 0x5.
5. Hold `poll` high for 20 cycles with 2 entries queued -> exactly one pop; 1 entry remains.
6. Assert `reset` mid-debounce with 2 entries queued -> `button_out` = 0 on the next edge. A button held through reset generates one event `DEBOUNCE_CYCLES`+2 edges after `reset` deasserts.

Source files
------------

// File: rtl/button_event_queue.sv
// Button event queue: four debounced buttons feed a small colour-event FIFO
// that the processor drains one entry per poll assertion.
module button_event_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DEPTH           = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        green_button,
    input  logic        yellow_button,
    input  logic        poll,
    output logic [31:0] button_out
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

    // Index order doubles as the colour code and as priority (lowest index wins)
    logic [3:0] btn_raw;
    assign btn_raw = {yellow_button, green_button, blue_button, red_button};

    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      stable_q, stable_d;
    logic [DbW-1:0]  db_cnt_q [4];
    logic [DbW-1:0]  db_cnt_d [4];
    logic [3:0]      pending_q, pending_d;
    logic [1:0]      mem_q [DEPTH];
    logic [1:0]      mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            poll_d_q, poll_d_d;

    logic [3:0] rise;
    logic [3:0] grant_oh;
    logic [1:0] grant_idx;
    logic       push_req, push, drop, pop_req, pop, empty, full;

    // Synchronizer shift and per-button debounce counters
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        rise     = '0;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    stable_d[i] = sync2_q[i];
                    rise[i]     = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Priority arbiter, FIFO push/pop and overflow bookkeeping
    always_comb begin
        grant_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_idx = 2'(i);
            end
        end
        push_req = |pending_q;
        grant_oh = push_req ? (4'b0001 << grant_idx) : 4'b0000;

        empty   = (count_q == '0);
        full    = (count_q == CntMax);
        pop_req = poll && !poll_d_q;
        pop     = pop_req && !empty;
        // A full FIFO still accepts the push when a pop frees the slot this cycle
        push    = push_req && (!full || pop);
        drop    = push_req && full && !pop;

        pending_d = (pending_q & ~grant_oh) | rise;
        poll_d_d  = poll;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = grant_idx;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (pop_req) begin
            overflow_d = 1'b0;
        end
    end

    // Read word: head entry while non-empty, sticky overflow always visible
    always_comb begin
        button_out      = '0;
        button_out[3]   = overflow_q;
        button_out[2]   = !empty;
        button_out[1:0] = empty ? 2'b00 : mem_q[rd_ptr_q];
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            poll_d_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            poll_d_q   <= poll_d_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
